// File: rtl/switch_stage_feeder_if.sv
// switch_stage_feeder_if
// Bundles the two handshakes around the switch-stage feeder.
//   Row input side : in_valid, in_ready, in_row
//   Pair output side: out_valid, out_ready, out_down, out_across,
//                     out_ctrl, out_pair_idx, out_tile_last
// Modports:
//   slave  - the feeder itself (accepts rows, produces pairs)
//   master - the environment around it (sends rows, consumes pairs)
interface switch_stage_feeder_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int ROWS  = 4
);
    localparam int PIDX_W = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [0:N-1][WIDTH-1:0]      in_row;

    logic                         out_valid;
    logic                         out_ready;
    logic [0:N-1][WIDTH-1:0]      out_down;
    logic [0:N-1][WIDTH-1:0]      out_across;
    logic                         out_ctrl;
    logic [PIDX_W-1:0]            out_pair_idx;
    logic                         out_tile_last;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_down, out_across,
               out_ctrl, out_pair_idx, out_tile_last
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_down, out_across,
               out_ctrl, out_pair_idx, out_tile_last
    );
endinterface

// File: rtl/switch_stage_feeder.sv
// switch_stage_feeder
// Upstream neighbour of the matrix-transpose switch stage. Rows arrive one
// per beat and fill one of two ping-pong banks; once a bank holds a full
// tile it is drained as row pairs (2k, 2k+1) with a per-pair control bit.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - switch_stage_feeder_if.slave
//          in_valid/in_ready/in_row            : row input handshake
//          out_valid/out_ready/out_down/out_across/out_ctrl/
//          out_pair_idx/out_tile_last          : registered pair output
module switch_stage_feeder #(
    parameter int WIDTH      = 8,
    parameter int N          = 4,
    parameter int ROWS       = 4,
    parameter bit CTRL_START = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_stage_feeder_if.slave bus
);
    localparam int PAIRS  = ROWS / 2;
    localparam int PIDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ROW_W  = $clog2(ROWS);

    typedef logic [0:N-1][WIDTH-1:0] row_t;

    row_t              mem_q [2][ROWS];

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ROW_W-1:0]  wr_row_q, wr_row_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PIDX_W-1:0] rd_pair_q, rd_pair_d;

    logic              out_valid_q, out_valid_d;
    row_t              out_down_q, out_down_d;
    row_t              out_across_q, out_across_d;
    logic              out_ctrl_q, out_ctrl_d;
    logic [PIDX_W-1:0] out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              wr_fire;
    logic              ld;
    logic              pair_last;
    row_t              rd_down, rd_across;

    // in_ready depends only on registered state, never on out_ready.
    assign wr_fire   = bus.in_valid && !full_q[wr_bank_q];
    // The output register refills whenever it is empty or being consumed.
    assign ld        = full_q[rd_bank_q] && (!out_valid_q || bus.out_ready);
    assign pair_last = (int'(rd_pair_q) == PAIRS - 1);

    // Row pair selection from the bank being drained.
    always_comb begin
        rd_down   = '0;
        rd_across = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r == 2 * int'(rd_pair_q))     rd_down   = mem_q[rd_bank_q][r];
            if (r == 2 * int'(rd_pair_q) + 1) rd_across = mem_q[rd_bank_q][r];
        end
    end

    // Bank storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (wr_fire && int'(wr_row_q) == r) mem_q[wr_bank_q][r] <= bus.in_row;
        end
    end

    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        wr_row_d     = wr_row_q;
        rd_bank_d    = rd_bank_q;
        rd_pair_d    = rd_pair_q;
        out_valid_d  = out_valid_q;
        out_down_d   = out_down_q;
        out_across_d = out_across_q;
        out_ctrl_d   = out_ctrl_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;

        if (wr_fire) begin
            if (int'(wr_row_q) == ROWS - 1) begin
                full_d[wr_bank_q] = 1'b1;
                wr_row_d          = '0;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + ROW_W'(1);
            end
        end

        // A bank set full and a bank freed on the same edge are always
        // different banks, so the two full_d updates never collide.
        if (ld) begin
            out_valid_d  = 1'b1;
            out_down_d   = rd_down;
            out_across_d = rd_across;
            out_ctrl_d   = CTRL_START ^ rd_pair_q[0];
            out_idx_d    = rd_pair_q;
            out_last_d   = pair_last;
            if (pair_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_pair_d         = '0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_pair_d = rd_pair_q + PIDX_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            wr_row_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_pair_q    <= '0;
            out_valid_q  <= 1'b0;
            out_down_q   <= '0;
            out_across_q <= '0;
            out_ctrl_q   <= CTRL_START;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            rd_bank_q    <= rd_bank_d;
            rd_pair_q    <= rd_pair_d;
            out_valid_q  <= out_valid_d;
            out_down_q   <= out_down_d;
            out_across_q <= out_across_d;
            out_ctrl_q   <= out_ctrl_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.in_ready      = !full_q[wr_bank_q];
    assign bus.out_valid     = out_valid_q;
    assign bus.out_down      = out_down_q;
    assign bus.out_across    = out_across_q;
    assign bus.out_ctrl      = out_ctrl_q;
    assign bus.out_pair_idx  = out_idx_q;
    assign bus.out_tile_last = out_last_q;
endmodule

// File: tb/tb_switch_stage_feeder.sv
module tb_switch_stage_feeder;
    typedef logic [0:3][7:0] row_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    switch_stage_feeder_if #(.WIDTH(8), .N(4), .ROWS(4)) bus ();
    switch_stage_feeder_if #(.WIDTH(8), .N(4), .ROWS(2)) bus2 ();

    switch_stage_feeder #(.WIDTH(8), .N(4), .ROWS(4), .CTRL_START(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    switch_stage_feeder #(.WIDTH(8), .N(4), .ROWS(2), .CTRL_START(1'b0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    localparam row_t R0 = {8'h0C, 8'h0B, 8'h2C, 8'h3C};
    localparam row_t R1 = {8'h0D, 8'h1D, 8'h1C, 8'h3D};
    localparam row_t R2 = {8'h10, 8'h11, 8'h12, 8'h13};
    localparam row_t R3 = {8'h20, 8'h21, 8'h22, 8'h23};

    // Row i holds bytes 4i .. 4i+3, element 0 leftmost.
    function automatic row_t mkrow(input int i);
        row_t r;
        for (int e = 0; e < 4; e++) r[e] = 8'(4 * i + e);
        return r;
    endfunction

    // {valid, down, across, ctrl, idx, tile_last}
    function automatic logic [67:0] obs1();
        return {bus.out_valid, bus.out_down, bus.out_across,
                bus.out_ctrl, bus.out_pair_idx, bus.out_tile_last};
    endfunction

    function automatic logic [67:0] obs2();
        return {bus2.out_valid, bus2.out_down, bus2.out_across,
                bus2.out_ctrl, bus2.out_pair_idx, bus2.out_tile_last};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [67:0] exp;
        apply_reset();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL reset_outputs: got %h want %h", obs1(), exp); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        exp = {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tests++; if (obs2() !== exp) begin fails++; $display("FAIL reset_outputs_rows2: got %h want %h", obs2(), exp); end
        tests++; if (bus2.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_rows2: got %b want 1", bus2.in_ready); end
    endtask

    task automatic test_single();
        row_t rs [4];
        logic [67:0] exp;
        rs = '{R0, R1, R2, R3};
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready row%0d: got %b want 1", i, bus.in_ready); end
            bus.in_valid = 1'b1; bus.in_row = rs[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", bus.out_valid); end
        @(negedge clk);
        exp = {1'b1, R0, R1, 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL single_pair0: got %h want %h", obs1(), exp); end
        @(negedge clk);
        exp = {1'b1, R2, R3, 1'b0, 1'b1, 1'b1};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL single_pair1: got %h want %h", obs1(), exp); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        row_t rs [4];
        logic [67:0] exp;
        rs = '{R0, R1, R2, R3};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_row = rs[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        exp = {1'b1, R0, R1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            tests++; if (obs1() !== exp) begin fails++; $display("FAIL bp_hold cycle%0d: got %h want %h", c, obs1(), exp); end
            if (c < 4) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp = {1'b1, R2, R3, 1'b0, 1'b1, 1'b1};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL bp_pair1: got %h want %h", obs1(), exp); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_duplicate: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [67:0] seen [8];
        logic [67:0] exp;
        logic        b;
        int          np = 0;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (bus.out_valid === 1'b1 && np < 8) begin seen[np] = obs1(); np++; end
            if (k < 8) begin
                tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready row%0d: got %b want 1", k, bus.in_ready); end
                bus.in_valid = 1'b1; bus.in_row = mkrow(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        tests++; if (np !== 4) begin fails++; $display("FAIL b2b_pair_count: got %0d want 4", np); end
        for (int p = 0; p < 4 && p < np; p++) begin
            b = p[0];
            exp = {1'b1, mkrow(2 * p), mkrow(2 * p + 1), ~b, b, b};
            tests++; if (seen[p] !== exp) begin fails++; $display("FAIL b2b_pair%0d: got %h want %h", p, seen[p], exp); end
        end
    endtask

    task automatic test_full();
        logic [67:0] exp;
        int acc = 0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            if (k >= 8) begin
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready cycle%0d: got %b want 0", k, bus.in_ready); end
            end
            if (bus.in_ready === 1'b1) acc++;
            bus.in_valid = 1'b1; bus.in_row = mkrow(k);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests++; if (acc !== 8) begin fails++; $display("FAIL full_accepted: got %0d want 8", acc); end
        exp = {1'b1, mkrow(0), mkrow(1), 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL full_pair0: got %h want %h", obs1(), exp); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_pulse_in_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp = {1'b1, mkrow(2), mkrow(3), 1'b0, 1'b1, 1'b1};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL full_after_pulse: got %h want %h", obs1(), exp); end
        // Loading pair 1 frees bank 0 on the pulse edge.
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_bank_freed: got %b want 1", bus.in_ready); end
        @(negedge clk);
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL full_pair1_hold: got %h want %h", obs1(), exp); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp = {1'b1, mkrow(4), mkrow(5), 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL full_tile1_pair0: got %h want %h", obs1(), exp); end
        @(negedge clk);
        exp = {1'b1, mkrow(6), mkrow(7), 1'b0, 1'b1, 1'b1};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL full_tile1_pair1: got %h want %h", obs1(), exp); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL full_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [67:0] exp;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1; bus.in_row = mkrow(20 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_stalled_valid: got %b want 1", bus.out_valid); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL mid_reset_outputs: got %h want %h", obs1(), exp); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_in_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_row = mkrow(40 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        exp = {1'b1, mkrow(40), mkrow(41), 1'b1, 1'b0, 1'b0};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL mid_fresh_pair0: got %h want %h", obs1(), exp); end
        @(negedge clk);
        exp = {1'b1, mkrow(42), mkrow(43), 1'b0, 1'b1, 1'b1};
        tests++; if (obs1() !== exp) begin fails++; $display("FAIL mid_fresh_pair1: got %h want %h", obs1(), exp); end
    endtask

    task automatic test_rows2();
        logic [67:0] exp;
        apply_reset();
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus2.in_ready !== 1'b1) begin fails++; $display("FAIL rows2_in_ready row%0d: got %b want 1", i, bus2.in_ready); end
            bus2.in_valid = 1'b1; bus2.in_row = mkrow(50 + i);
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        tests++; if (bus2.out_valid !== 1'b0) begin fails++; $display("FAIL rows2_early_valid: got %b want 0", bus2.out_valid); end
        @(negedge clk);
        exp = {1'b1, mkrow(50), mkrow(51), 1'b0, 1'b0, 1'b1};
        tests++; if (obs2() !== exp) begin fails++; $display("FAIL rows2_pair0: got %h want %h", obs2(), exp); end
        @(negedge clk);
        tests++; if (bus2.out_valid !== 1'b0) begin fails++; $display("FAIL rows2_drained: got %b want 0", bus2.out_valid); end
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.in_row = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.in_row = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_rows2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
